// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Unsupported modes yield 0; the caller never transmits the bit then.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: TICK marks the last clock of every CLK_DIV-cycle bit.
module baud_tick_gen #(
  parameter int CLK_DIV = 434
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLOCK) begin
    if (RESET || CLR || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign TICK = !CLR && (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from the FIFO read port and serialises it as 8N1/8E1/8O1 (1 or 2 stops).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        FIFO_EMPTY_N,
  input  logic [7:0]  FIFO_DATA,
  output logic        FIFO_READ,
  output logic        TX,
  output logic        BUSY,
  output logic        BYTE_DONE,
  output logic [15:0] FRAME_CNT
);

  localparam logic PAR_EN   = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam logic TWO_STOP = (STOP_BITS == 2);

  tx_state_t   r_state;
  logic [7:0]  r_shift;
  logic        r_par;
  logic [2:0]  r_bit_cnt;
  logic        r_tx;
  logic        r_fifo_read;
  logic        r_busy;
  logic        r_byte_done;
  logic [15:0] r_frame_cnt;
  logic        w_tick;
  logic        w_baud_clr;

  // Holding the timer clear until START makes every bit start from count 0;
  // later state changes only happen on a tick, where the counter wraps anyway.
  assign w_baud_clr = (r_state == IDLE) || (r_state == POP) || (r_state == LOAD);

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .CLR  (w_baud_clr),
    .TICK (w_tick)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx        <= 1'b1;
      r_fifo_read <= 1'b0;
      r_busy      <= 1'b0;
      r_byte_done <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_fifo_read <= 1'b0;
      r_byte_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ENABLE && FIFO_EMPTY_N) begin
            r_state     <= POP;
            r_fifo_read <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        POP: r_state <= LOAD;
        LOAD: begin
          r_shift   <= FIFO_DATA;
          r_par     <= calc_parity(FIFO_DATA, PARITY);
          r_bit_cnt <= '0;
          r_tx      <= 1'b0;
          r_state   <= START;
        end
        START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (PAR_EN) begin
                r_tx    <= r_par;
                r_state <= PAR;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end
        end
        PAR: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          // r_bit_cnt counts completed stop bits when two are configured.
          if (w_tick) begin
            if (TWO_STOP && (r_bit_cnt == 3'd0)) begin
              r_bit_cnt <= 3'd1;
            end else begin
              r_bit_cnt   <= '0;
              r_busy      <= 1'b0;
              r_byte_done <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_state     <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FIFO_READ = r_fifo_read;
  assign TX        = r_tx;
  assign BUSY      = r_busy;
  assign BYTE_DONE = r_byte_done;
  assign FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Four transmitter configurations driven in lockstep against a frame-level reference model.
module tb_fifo_uart_tx;

  localparam int N = 4;
  int DIVS  [N] = '{4, 4, 2, 4};
  int PARS  [N] = '{0, 1, 0, 2};
  int STOPS [N] = '{1, 2, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, en, ne;
  logic [7:0]   fd [N];
  logic [N-1:0] rd, tx, busy, done;
  logic [15:0]  fc [N];

  fifo_uart_tx #(.CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) dut_a (
    .CLOCK(clk), .RESET(rst[0]), .ENABLE(en[0]), .FIFO_EMPTY_N(ne[0]), .FIFO_DATA(fd[0]),
    .FIFO_READ(rd[0]), .TX(tx[0]), .BUSY(busy[0]), .BYTE_DONE(done[0]), .FRAME_CNT(fc[0]));
  fifo_uart_tx #(.CLK_DIV(4), .PARITY(1), .STOP_BITS(2)) dut_b (
    .CLOCK(clk), .RESET(rst[1]), .ENABLE(en[1]), .FIFO_EMPTY_N(ne[1]), .FIFO_DATA(fd[1]),
    .FIFO_READ(rd[1]), .TX(tx[1]), .BUSY(busy[1]), .BYTE_DONE(done[1]), .FRAME_CNT(fc[1]));
  fifo_uart_tx #(.CLK_DIV(2), .PARITY(0), .STOP_BITS(1)) dut_c (
    .CLOCK(clk), .RESET(rst[2]), .ENABLE(en[2]), .FIFO_EMPTY_N(ne[2]), .FIFO_DATA(fd[2]),
    .FIFO_READ(rd[2]), .TX(tx[2]), .BUSY(busy[2]), .BYTE_DONE(done[2]), .FRAME_CNT(fc[2]));
  fifo_uart_tx #(.CLK_DIV(4), .PARITY(2), .STOP_BITS(1)) dut_d (
    .CLOCK(clk), .RESET(rst[3]), .ENABLE(en[3]), .FIFO_EMPTY_N(ne[3]), .FIFO_DATA(fd[3]),
    .FIFO_READ(rd[3]), .TX(tx[3]), .BUSY(busy[3]), .BYTE_DONE(done[3]), .FRAME_CNT(fc[3]));

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  logic [7:0]  mem [N][64];
  int          wp [N];
  int          rp [N];
  bit          fgate [N];
  bit          pending [N];
  bit          active [N];
  int          pos [N];
  bit          fbits [N][12];
  int          flen [N];
  logic [15:0] mcnt [N];
  bit          req [N];
  bit          rst_e [N];
  bit          prev_rd [N];
  bit          prev_tx [N];
  int          npops [N];
  int          first_fall [N];
  int          first_done [N];
  bit          partx [N];
  int          popcyc [$];
  int          snap;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d]: got %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    mem[k][wp[k] % 64] = b;
    wp[k]++;
  endtask

  // Expected line levels for one frame, one entry per bit period.
  task automatic build_frame(input int k, input logic [7:0] b);
    int ones;
    int n;
    ones = 0;
    fbits[k][0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fbits[k][1 + i] = b[i];
      ones += int'(b[i]);
    end
    n = 9;
    if (PARS[k] == 1) begin
      fbits[k][9] = (ones % 2) == 1;
      n = 10;
    end else if (PARS[k] == 2) begin
      fbits[k][9] = (ones % 2) == 0;
      n = 10;
    end
    fbits[k][n]     = 1'b1;
    fbits[k][n + 1] = 1'b1;
    flen[k] = n + ((STOPS[k] == 2) ? 2 : 1);
  endtask

  task automatic step();
    bit ed;
    bit er;
    bit et;
    for (int k = 0; k < N; k++) begin
      ne[k]    = fgate[k] && (wp[k] != rp[k]);
      req[k]   = !active[k] && en[k] && ne[k] && !rst[k];
      rst_e[k] = rst[k];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      ed = 1'b0;
      er = 1'b0;
      et = 1'b1;
      if (rst_e[k]) begin
        active[k] = 1'b0;
        mcnt[k]   = 16'd0;
      end else begin
        if (active[k]) begin
          pos[k]++;
          if (pos[k] == flen[k] * DIVS[k]) begin
            active[k] = 1'b0;
            ed = 1'b1;
            mcnt[k] = mcnt[k] + 16'd1;
          end
        end
        if (req[k]) begin
          active[k] = 1'b1;
          pos[k] = -2;
          build_frame(k, mem[k][rp[k] % 64]);
          er = 1'b1;
        end
      end
      if (active[k] && pos[k] >= 0) et = fbits[k][pos[k] / DIVS[k]];
      chk("tx", k, 32'(tx[k]), 32'(et));
      chk("fifo_read", k, 32'(rd[k]), 32'(er));
      chk("busy", k, 32'(busy[k]), 32'(active[k]));
      chk("byte_done", k, 32'(done[k]), 32'(ed));
      chk("frame_cnt", k, 32'(fc[k]), 32'(mcnt[k]));
      chk("read_consec", k, 32'(rd[k] & prev_rd[k]), 32'd0);
      if (rd[k]) begin
        npops[k]++;
        if (k == 0) popcyc.push_back(cyc);
      end
      if (prev_tx[k] && !tx[k] && first_fall[k] < 0) first_fall[k] = cyc;
      if (done[k] && first_done[k] < 0) first_done[k] = cyc;
      if (active[k] && pos[k] == 9 * DIVS[k] + 1) partx[k] = tx[k];
      prev_tx[k] = tx[k];
      prev_rd[k] = rd[k];
      // Popped data appears only in the cycle after the read strobe.
      if (pending[k]) begin
        fd[k] = mem[k][rp[k] % 64];
        rp[k]++;
        pending[k] = 1'b0;
      end else begin
        fd[k] = 8'($urandom);
      end
      if (rd[k]) pending[k] = 1'b1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_all_idle(input int budget);
    int c;
    bit any;
    c = 0;
    any = 1'b1;
    while (any && c < budget) begin
      step();
      c++;
      any = 1'b0;
      for (int k = 0; k < N; k++)
        if (active[k] || (fgate[k] && en[k] && wp[k] != rp[k])) any = 1'b1;
    end
    chk("idle_timeout", -1, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_bit3(input int k);
    int c;
    c = 0;
    while (!(active[k] && pos[k] == 4 * DIVS[k] + 1) && c < 80) begin
      step();
      c++;
    end
    chk("reach_bit3", k, 32'(c < 80), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = '1;
    en  = '0;
    ne  = '0;
    for (int k = 0; k < N; k++) begin
      fd[k] = 8'h00;
      wp[k] = 0;
      rp[k] = 0;
      fgate[k] = 1'b1;
      pending[k] = 1'b0;
      active[k] = 1'b0;
      pos[k] = 0;
      flen[k] = 10;
      mcnt[k] = 16'd0;
      prev_rd[k] = 1'b0;
      prev_tx[k] = 1'b1;
      npops[k] = 0;
      first_fall[k] = -1;
      first_done[k] = -1;
      partx[k] = 1'b0;
    end

    // Reset state
    run(3);
    chk("rst_tx", -1, 32'(tx), 32'hF);
    chk("rst_busy", -1, 32'(busy), 32'h0);
    chk("rst_read", -1, 32'(rd), 32'h0);
    rst = '0;

    // Single byte 0xA5 on every configuration
    for (int k = 0; k < N; k++) push(k, 8'hA5);
    en = '1;
    run(70);
    for (int k = 0; k < N; k++) begin
      chk("single_cnt", k, 32'(fc[k]), 32'd1);
      chk("single_pops", k, 32'(npops[k]), 32'd1);
    end
    chk("frame_len", 0, 32'(first_done[0] - first_fall[0]), 32'd40);
    chk("frame_len", 1, 32'(first_done[1] - first_fall[1]), 32'd48);
    chk("frame_len", 2, 32'(first_done[2] - first_fall[2]), 32'd20);
    chk("frame_len", 3, 32'(first_done[3] - first_fall[3]), 32'd44);
    chk("even_par", 1, 32'(partx[1]), 32'd0);
    chk("odd_par", 3, 32'(partx[3]), 32'd1);

    // Back-to-back frames
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    for (int k = 1; k < N; k++)
      for (int i = 0; i < 3; i++) push(k, 8'($urandom));
    wait_all_idle(400);
    chk("b2b_cnt", 0, 32'(fc[0]), 32'd4);
    chk("b2b_pops", 0, 32'(popcyc.size()), 32'd4);
    if (popcyc.size() == 4) begin
      chk("b2b_gap1", 0, 32'(popcyc[2] - popcyc[1]), 32'd43);
      chk("b2b_gap2", 0, 32'(popcyc[3] - popcyc[2]), 32'd43);
    end

    // Empty FIFO, then disabled with data present
    snap = npops[0];
    for (int k = 0; k < N; k++) fgate[k] = 1'b0;
    run(100);
    for (int k = 0; k < N; k++) fgate[k] = 1'b1;
    en = '0;
    push(0, 8'h5A);
    run(100);
    chk("idle_pops", 0, 32'(npops[0]), 32'(snap));
    chk("idle_busy", -1, 32'(busy), 32'h0);
    chk("idle_tx", -1, 32'(tx), 32'hF);

    // ENABLE dropped during data bit 3
    push(0, 8'hC3);
    en = '1;
    wait_bit3(0);
    en = '0;
    run(80);
    chk("endrop_pops", 0, 32'(npops[0]), 32'(snap + 1));
    chk("endrop_cnt", 0, 32'(fc[0]), 32'd5);
    chk("endrop_left", 0, 32'(wp[0] - rp[0]), 32'd1);

    // RESET during data bit 3
    en = '1;
    wait_bit3(0);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    en = '0;
    chk("rst_mid_tx", 0, 32'(tx[0]), 32'd1);
    chk("rst_mid_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_mid_cnt", 0, 32'(fc[0]), 32'd0);
    run(60);
    chk("rst_mid_after", 0, 32'(fc[0]), 32'd0);

    // Randomised traffic with ENABLE and FIFO availability toggling
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 6; i++) push(k, 8'($urandom));
    for (int it = 0; it < 60; it++) begin
      en = 4'($urandom);
      for (int k = 0; k < N; k++) fgate[k] = ($urandom_range(0, 3) != 0);
      run(10);
    end
    en = '1;
    for (int k = 0; k < N; k++) fgate[k] = 1'b1;
    wait_all_idle(1500);
    for (int k = 0; k < N; k++) chk("rand_drained", k, 32'(wp[k] - rp[k]), 32'd0);

    // FRAME_CNT wrap on the CLK_DIV=2 instance
    force dut_c.r_frame_cnt = 16'hFFFF;
    mcnt[2] = 16'hFFFF;
    step();
    release dut_c.r_frame_cnt;
    step();
    chk("wrap_pre", 2, 32'(fc[2]), 32'hFFFF);
    push(2, 8'h81);
    run(30);
    chk("wrap_post", 2, 32'(fc[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
